// File: rtl/add_sub_seq.sv
// Chunk-serial adder/subtractor: one CHUNK-bit slice per cycle through a registered carry,
// with a valid/ready handshake on both sides and compare flags taken from the full result.
module add_sub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             is_not_equal,
   output logic             is_less_than
);

   localparam int NUM_SLICES = WIDTH / CHUNK;
   localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t             stateCur;
   state_t             stateNext;
   logic [WIDTH-1:0]   opA;
   logic [WIDTH-1:0]   opB;        // already inverted for subtraction
   logic               subReg;
   logic               carryReg;
   logic [IDX_W-1:0]   sliceIdx;
   logic [CHUNK:0]     sliceSum;
   logic [WIDTH-1:0]   fullSum;
   logic               ovfNext;
   logic               accept;
   logic               lastSlice;

   // The last slice is merged with the partial result so flags see all WIDTH bits at once.
   always_comb begin
      sliceSum = {1'b0, opA[sliceIdx*CHUNK +: CHUNK]} + {1'b0, opB[sliceIdx*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, carryReg};
      fullSum  = result;
      fullSum[sliceIdx*CHUNK +: CHUNK] = sliceSum[CHUNK-1:0];
      ovfNext  = (opA[WIDTH-1] == opB[WIDTH-1]) && (fullSum[WIDTH-1] != opA[WIDTH-1]);
   end

   assign lastSlice = (sliceIdx == LAST_IDX);
   assign out_valid = (stateCur == DONE);
   assign accept    = in_valid && in_ready;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      in_ready  = 1'b0;
      stateNext = stateCur;
      if (reset_n) begin
         case (stateCur)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
         endcase
      end
      case (stateCur)
         IDLE:    if (accept) stateNext = RUN;
         RUN:     if (lastSlice) stateNext = DONE;
         DONE:    if (out_ready) stateNext = in_valid ? RUN : IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: datapath registers are reset too, so result and flags read 0 straight out of reset.
      if (!reset_n) begin
         stateCur     <= IDLE;
         opA          <= '0;
         opB          <= '0;
         subReg       <= 1'b0;
         carryReg     <= 1'b0;
         sliceIdx     <= '0;
         result       <= '0;
         carry_out    <= 1'b0;
         overflow     <= 1'b0;
         is_not_equal <= 1'b0;
         is_less_than <= 1'b0;
      end else begin
         stateCur <= stateNext;
         if (accept) begin
            opA      <= data_a;
            opB      <= sub ? ~data_b : data_b;
            subReg   <= sub;
            carryReg <= sub;
            sliceIdx <= '0;
         end else if (stateCur == RUN) begin
            result[sliceIdx*CHUNK +: CHUNK] <= sliceSum[CHUNK-1:0];
            carryReg <= sliceSum[CHUNK];
            if (lastSlice) begin
               carry_out    <= sliceSum[CHUNK];
               overflow     <= ovfNext;
               is_not_equal <= subReg && (|fullSum);
               is_less_than <= subReg && (fullSum[WIDTH-1] ^ ovfNext);
            end else begin
               sliceIdx <= sliceIdx + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/add_sub_seq.md
Name: add_sub_seq

Overview:
- Parametrised, chunk-serial signed/unsigned adder-subtractor for the multdiv datapath.
- Adds one CHUNK-bit slice per cycle through a registered carry, so area scales with CHUNK rather than WIDTH.
- Produces the sum plus not-equal, signed less-than, overflow and carry-out flags.
- Uses a valid/ready handshake on both input and output, so it can sit between the operand latch and the multdiv result mux.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; N = WIDTH/CHUNK slices; CHUNK == WIDTH is legal (N = 1).

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and mode are presented.
- in_ready  output  1  block can accept an operation this cycle.
- data_a  input  WIDTH  operand A.
- data_b  input  WIDTH  operand B.
- sub  input  1  1 = A-B, 0 = A+B.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum or difference, modulo 2^WIDTH.
- carry_out  output  1  carry from the MSB slice; for sub, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.
- is_not_equal  output  1  sub=1: A != B; forced 0 when sub=0.
- is_less_than  output  1  sub=1: signed A < B; forced 0 when sub=0.

Behaviour:
- Reset and synchronicity
  - Reset is synchronous, active-low. While reset_n = 0 on a rising edge, state goes to IDLE, all registers clear, and out_valid, result and all flags go to 0.
  - in_ready = 0 while reset_n is low.
- IDLE state
  - in_ready = 1.
  - On an edge with in_valid = 1:
    - capture A;
    - capture B' = sub ? ~B : B, plus B[WIDTH-1] and sub;
    - set carry register = sub and slice index = 0;
    - go to RUN.
- RUN state
  - in_ready = 0.
  - Each edge computes slice i: {c, s} = A[i] + B'[i] + carry. It writes s into result[i] and c into carry, then increments i.
  - Input pins are ignored during RUN; only captured values are used.
  - On the edge that processes slice N-1, also register:
    - carry_out = final carry;
    - overflow = (A_msb == B'_msb) && (S_msb != A_msb);
    - is_not_equal = sub && |S;
    - is_less_than = sub && (S_msb ^ overflow).
  - That same edge moves to DONE and sets out_valid = 1.
- Latency
  - out_valid rises exactly N edges after the accepting edge: 4 for the defaults, 1 when N = 1.
- DONE state
  - out_valid = 1; result and flags held stable until out_ready = 1.
  - in_ready = out_ready. This is a combinational path and is allowed.
  - On an edge with out_ready = 1:
    - out_valid drops;
    - if in_valid is also 1, the new operation is captured on that edge and the state goes straight to RUN; otherwise the state goes to IDLE.
  - Back-to-back throughput is one operation per N+1 cycles.
- Held values
  - result and flags keep their last values outside DONE. They are don't-care to consumers while out_valid = 0.
- Slice index
  - Counter width is max(1, clog2(N)).
  - It must not wrap into slice 0 without an accept; no reuse of stale carry.
- Reset mid-operation
  - A reset during RUN or DONE aborts the operation. No out_valid is produced.
  - in_ready = 1 on the first cycle after reset_n returns high.
- Flag semantics
  - is_less_than must be correct even when the subtraction overflows.
  - Flags are evaluated on the full WIDTH-bit result, never on a single slice.

Test Plan:
1. WIDTH=32, CHUNK=8, sub=0, A=0x0000_00FF, B=0x0000_0001 -> out_valid exactly 4 edges after accept; result=0x0000_0100, carry_out=0, overflow=0, lt=0, ne=0.
2. sub=0, A=0x7FFF_FFFF, B=0x0000_0001 -> result=0x8000_0000, overflow=1, carry_out=0; then A=0xFFFF_FFFF, B=1 -> result=0, carry_out=1, overflow=0.
3. sub=1, A=0x8000_0000, B=0x0000_0001 -> result=0x7FFF_FFFF, overflow=1, is_less_than=1, is_not_equal=1, carry_out=1.
4. sub=1, A=B=0x0000_0005 -> result=0, is_not_equal=0, is_less_than=0, carry_out=1; then A=0xFFFF_FFFE (-2), B=3 -> lt=1, overflow=0.
5. Backpressure and back-to-back, in three steps:
   - hold out_ready=0 for 3 cycles in DONE -> result and flags stable;
   - with in_valid=1 and the next operands waiting, raise out_ready -> accept occurs on that edge;
   - next out_valid follows N edges later.
6. Reset and alternate parameters, in two steps:
   - assert reset_n=0 on the 2nd RUN edge -> out_valid never rises, all outputs 0, in_ready=1 after release;
   - repeat scenarios 1-4 with WIDTH=16/CHUNK=4 (latency 4) and WIDTH=CHUNK=32 (latency 1).
